// File: rtl/sreg_bank_pkg.sv
// Shared types and helpers for the sreg_bank threshold register block.
// Imported by the channel slice and the Wishbone front end.
package sreg_bank_pkg;

    localparam int WB_DW    = 32;
    localparam int N_CH_DEF = 4;
    localparam int LO_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } rd_state_t;

    // True when byte lane k lies wholly inside the RW storage field.
    function automatic logic byte_in_lo(input int k, input int lo_w);
        return ((k + 1) * 8) <= lo_w;
    endfunction

endpackage

// File: rtl/sreg_bank_chan.sv
// One channel slice: RW storage with byte merge, wire-field write hold
// and the per-channel write/read strobes.
module sreg_bank_chan
    import sreg_bank_pkg::*;
#(
    parameter int LO_W = LO_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    i_we,
    input  logic [3:0]              i_sel,
    input  logic [WB_DW-1:0]        i_dat,
    input  logic                    i_rd_req,
    output logic [LO_W-1:0]         o_lo,
    output logic [WB_DW-LO_W-1:0]   o_hi,
    output logic                    o_wr,
    output logic                    o_rd
);

    localparam int HI_W = WB_DW - LO_W;
    localparam int LO_B = LO_W / 8;

    logic              r_lpend;
    logic [LO_B-1:0]   r_lsel;
    logic [LO_W-1:0]   r_ldat;
    logic [LO_W-1:0]   r_lo;
    logic [HI_W-1:0]   r_hi;
    logic              r_wr;
    logic              r_rd;
    logic [LO_W-1:0]   w_lo_nxt;
    logic [HI_W-1:0]   w_hi_nxt;
    logic [3:0]        w_hisel;

    // Lo bytes merge from the registered request, hi bytes from the live bus.
    for (genvar k = 0; k < 4; k++) begin : g_byte
        if (byte_in_lo(k, LO_W)) begin : g_lo
            assign w_lo_nxt[k*8 +: 8] = r_lsel[k] ? r_ldat[k*8 +: 8]
                                                  : r_lo[k*8 +: 8];
            assign w_hisel[k] = 1'b0;
        end else begin : g_hi
            assign w_hi_nxt[k*8-LO_W +: 8] = i_sel[k] ? i_dat[k*8 +: 8]
                                                      : r_hi[k*8-LO_W +: 8];
            assign w_hisel[k] = i_sel[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_lpend <= 1'b0;
            r_lsel  <= '0;
            r_ldat  <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
        end else begin
            r_lpend <= i_we;
            r_wr    <= i_we & (|w_hisel);
            r_rd    <= i_rd_req;
            if (i_we) begin
                r_lsel <= i_sel[LO_B-1:0];
                r_ldat <= i_dat[LO_W-1:0];
                r_hi   <= w_hi_nxt;
            end
            if (r_lpend) begin
                r_lo <= w_lo_nxt;
            end
        end
    end

    assign o_lo = r_lo;
    assign o_hi = r_hi;
    assign o_wr = r_wr;
    assign o_rd = r_rd;

endmodule

// File: rtl/sreg_bank.sv
// Pipelined Wishbone slave holding N_CH channel threshold words, with an
// optional external read handshake and timeout on the wire fields.
module sreg_bank
    import sreg_bank_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int LO_W    = LO_W_DEF,
    parameter int ADR_W   = 6,
    parameter int EXT_RD  = 0,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_we_i,
    input  logic [ADR_W-1:0]           wb_adr_i,
    input  logic [3:0]                 wb_sel_i,
    input  logic [WB_DW-1:0]           wb_dat_i,
    output logic                       wb_ack_o,
    output logic                       wb_err_o,
    output logic                       wb_rty_o,
    output logic                       wb_stall_o,
    output logic [WB_DW-1:0]           wb_dat_o,
    output logic [N_CH*LO_W-1:0]       thr_lo_o,
    input  logic [N_CH*(WB_DW-LO_W)-1:0] thr_hi_i,
    output logic [N_CH*(WB_DW-LO_W)-1:0] thr_hi_o,
    output logic [N_CH-1:0]            thr_wr_o,
    output logic [N_CH-1:0]            thr_rd_o,
    input  logic [N_CH-1:0]            thr_rack_i
);

    localparam int HI_W  = WB_DW - LO_W;
    localparam int IDX_W = ADR_W - 2;

    rd_state_t         r_state;
    rd_state_t         w_state_nxt;
    logic              r_wip;
    logic [IDX_W-1:0]  r_widx;
    logic [IDX_W-1:0]  r_ridx;
    logic [7:0]        r_cnt;
    logic              r_ack;
    logic              r_err;
    logic [WB_DW-1:0]  r_dat;

    logic              w_en;
    logic              w_busy;
    logic              w_acc;
    logic              w_acc_rd;
    logic              w_acc_wr;
    logic [IDX_W-1:0]  w_idx;
    logic              w_inrng;
    logic              w_widx_ok;
    logic [N_CH-1:0]   w_we_ch;
    logic [N_CH-1:0]   w_rd_ch;
    logic [WB_DW-1:0]  w_rd_word;
    logic [WB_DW-1:0]  w_ext_word;
    logic              w_rack;
    logic              w_fsm_ack;
    logic              w_fsm_err;
    logic              w_cnt_inc;
    logic              w_unused;

    assign w_idx     = wb_adr_i[ADR_W-1:2];
    assign w_unused  = &{1'b0, wb_adr_i[1:0]};
    assign w_inrng   = 32'(w_idx) < N_CH;
    assign w_widx_ok = 32'(r_widx) < N_CH;

    // Busy spans the whole transaction including its response cycle, so a
    // request still held by the master during ack/err is not taken twice.
    assign w_en     = wb_cyc_i & wb_stb_i;
    assign w_busy   = r_wip | r_ack | r_err | (r_state != IDLE);
    assign w_acc    = w_en & ~w_busy;
    assign w_acc_rd = w_acc & ~wb_we_i;
    assign w_acc_wr = w_acc & wb_we_i;

    assign wb_stall_o = w_en & ~(r_ack | r_err);
    assign wb_rty_o   = 1'b0;
    assign wb_ack_o   = r_ack;
    assign wb_err_o   = r_err;
    assign wb_dat_o   = r_dat;

    always_comb begin
        w_we_ch    = '0;
        w_rd_ch    = '0;
        w_rd_word  = '0;
        w_ext_word = '0;
        w_rack     = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (32'(w_idx) == c) begin
                w_we_ch[c] = w_acc_wr;
                w_rd_ch[c] = w_acc_rd & (EXT_RD != 0);
                w_rd_word  = {thr_hi_i[c*HI_W +: HI_W],
                              thr_lo_o[c*LO_W +: LO_W]};
            end
            if (32'(r_ridx) == c) begin
                w_rack     = thr_rack_i[c];
                w_ext_word = {thr_hi_i[c*HI_W +: HI_W],
                              thr_lo_o[c*LO_W +: LO_W]};
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fsm_ack   = 1'b0;
        w_fsm_err   = 1'b0;
        w_cnt_inc   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if ((EXT_RD != 0) && w_acc_rd && w_inrng) begin
                    w_state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (w_rack) begin
                    w_state_nxt = RESP;
                    w_fsm_ack   = 1'b1;
                end else if (r_cnt == 8'(TIMEOUT)) begin
                    w_state_nxt = RESP;
                    w_fsm_err   = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_ridx  <= '0;
            r_cnt   <= '0;
            r_wip   <= 1'b0;
            r_widx  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wip   <= w_acc_wr;
            if (w_acc_rd) begin
                r_ridx <= w_idx;
            end
            if (w_acc_wr) begin
                r_widx <= w_idx;
            end
            if (r_state != RD_WAIT) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // At most one of these sources fires per cycle: one transaction at a time.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (w_acc_rd) begin
                if (!w_inrng) begin
                    r_err <= 1'b1;
                    r_dat <= '0;
                end else if (EXT_RD == 0) begin
                    r_ack <= 1'b1;
                    r_dat <= w_rd_word;
                end
            end
            if (r_wip) begin
                r_ack <= w_widx_ok;
                r_err <= ~w_widx_ok;
                r_dat <= '0;
            end
            if (w_fsm_ack) begin
                r_ack <= 1'b1;
                r_dat <= w_ext_word;
            end
            if (w_fsm_err) begin
                r_err <= 1'b1;
                r_dat <= '0;
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        sreg_bank_chan #(
            .LO_W (LO_W)
        ) u_chan (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .i_we     (w_we_ch[c]),
            .i_sel    (wb_sel_i),
            .i_dat    (wb_dat_i),
            .i_rd_req (w_rd_ch[c]),
            .o_lo     (thr_lo_o[c*LO_W +: LO_W]),
            .o_hi     (thr_hi_o[c*HI_W +: HI_W]),
            .o_wr     (thr_wr_o[c]),
            .o_rd     (thr_rd_o[c])
        );
    end

endmodule
